// File: rtl/sam_trace_pkg.sv
// Shared types and constants for the NPC/WB trace UART transmitter.
// Optional build macro: SAM_TRACE_CHECKSUM_EN appends an XOR checksum byte to each frame.
package sam_trace_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef SAM_TRACE_CHECKSUM_EN
  localparam int FRAME_BYTES = 10;
`else
  localparam int FRAME_BYTES = 9;
`endif

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] wb;
  } trace_rec_t;

  // Select byte idx of the frame: sync, NPC little-endian, WB little-endian, optional checksum.
  function automatic logic [7:0] frame_byte(input trace_rec_t rec, input logic [3:0] idx);
    logic [7:0] b;
    b = SYNC_BYTE;
    case (idx)
      4'd1:    b = rec.npc[7:0];
      4'd2:    b = rec.npc[15:8];
      4'd3:    b = rec.npc[23:16];
      4'd4:    b = rec.npc[31:24];
      4'd5:    b = rec.wb[7:0];
      4'd6:    b = rec.wb[15:8];
      4'd7:    b = rec.wb[23:16];
      4'd8:    b = rec.wb[31:24];
`ifdef SAM_TRACE_CHECKSUM_EN
      4'd9:    b = rec.npc[7:0] ^ rec.npc[15:8] ^ rec.npc[23:16] ^ rec.npc[31:24] ^
                   rec.wb[7:0]  ^ rec.wb[15:8]  ^ rec.wb[23:16]  ^ rec.wb[31:24];
`endif
      default: b = SYNC_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sam_trace_fifo.sv
// Synchronous record FIFO for the trace transmitter. A push into a full FIFO
// is still accepted when a pop happens in the same cycle.
module sam_trace_fifo
  import sam_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   RN,
  input  logic                   push,
  input  logic                   pop,
  input  trace_rec_t             wr_data,
  output trace_rec_t             rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  trace_rec_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage array, written only on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy; reset empties the FIFO and discards queued records.
  always_ff @(posedge clk) begin
    if (RN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/sam_wb_trace_tx.sv
// Trace transmitter: captures an {NPC, WB} record whenever NPC changes,
// queues it, and sends it as a framed 8N1 UART byte stream.
// Optional build macro: SAM_TRACE_CHECKSUM_EN (10-byte frame with XOR checksum).
module sam_wb_trace_tx
  import sam_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 8
) (
  input  logic                   clk,
  input  logic                   RN,
  input  logic                   trace_en,
  input  logic [31:0]            npc_in,
  input  logic [31:0]            wb_in,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [15:0]            frame_cnt
);

  localparam int              TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]   BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_BYTE = 4'(FRAME_BYTES - 1);

  tx_state_t     state;
  tx_state_t     state_next;
  logic [31:0]   npc_q;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  trace_rec_t    rd_rec;
  trace_rec_t    frame_q;
  logic [TW-1:0] bit_timer;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic          timer_done;
  logic [7:0]    cur_byte;

  assign push       = trace_en && (npc_in != npc_q);
  assign timer_done = (bit_timer == BIT_LAST);
  assign busy       = (state != IDLE);
  assign cur_byte   = frame_byte(frame_q, byte_idx);

  sam_trace_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .RN     (RN),
    .push   (push),
    .pop    (pop),
    .wr_data({npc_in, wb_in}),
    .rd_data(rd_rec),
    .level  (fifo_level),
    .full   (full),
    .empty  (empty)
  );

  // Previous NPC, tracked every cycle so a retirement shows up as a change.
  always_ff @(posedge clk) begin
    if (RN) begin
      npc_q <= '0;
    end else begin
      npc_q <= npc_in;
    end
  end

  // Sticky flag for a record dropped because the FIFO was full with no pop.
  always_ff @(posedge clk) begin
    if (RN) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Serialiser state register.
  always_ff @(posedge clk) begin
    if (RN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; IDLE pops a queued record the moment one is available.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (timer_done) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (timer_done && (bit_idx == 3'd7)) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (timer_done) begin
          state_next = (byte_idx == LAST_BYTE) ? IDLE : START;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level: idle/stop high, start low, data bits LSB first.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_idx];
      default: tx = 1'b1;
    endcase
  end

  // Bit timer, bit/byte indices, frame register and completed-frame counter.
  always_ff @(posedge clk) begin
    if (RN) begin
      bit_timer <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      frame_q   <= '0;
      frame_cnt <= '0;
    end else begin
      if ((state == IDLE) || (state_next != state) || timer_done) begin
        bit_timer <= '0;
      end else begin
        bit_timer <= bit_timer + TW'(1);
      end

      if (state == START) begin
        bit_idx <= '0;
      end else if ((state == DATA) && timer_done) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (pop) begin
        byte_idx <= '0;
        frame_q  <= rd_rec;
      end else if ((state == STOP) && timer_done && (byte_idx != LAST_BYTE)) begin
        byte_idx <= byte_idx + 4'd1;
      end

      if ((state == STOP) && timer_done && (byte_idx == LAST_BYTE)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sam_wb_trace_tx.sv
// Self-checking bench for sam_wb_trace_tx: table of frame vectors plus
// directed sequences for stable NPC, overflow, mid-frame reset and enable gating.
// Honours SAM_TRACE_CHECKSUM_EN for frame length and the checksum byte.
module tb_sam_wb_trace_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef SAM_TRACE_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int SPAN = NB * 10 * CPB;

  logic                   clk      = 1'b0;
  logic                   RN       = 1'b1;
  logic                   trace_en = 1'b0;
  logic [31:0]            npc_in   = '0;
  logic [31:0]            wb_in    = '0;
  logic                   tx;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic [15:0]            frame_cnt;

  int         total   = 0;
  int         bad     = 0;
  int         mon_err = 0;
  bit         mon_en  = 1'b0;
  logic [7:0] rx_byte;
  logic [7:0] rx_q[$];

  // Frame bytes packed MSB-first: byte0 in [79:72] ... byte9 (checksum) in [7:0].
  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] wb;
    logic [79:0] exp_bytes;
  } vec_t;

  vec_t vecs [4];

  sam_wb_trace_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk       (clk),
    .RN        (RN),
    .trace_en  (trace_en),
    .npc_in    (npc_in),
    .wb_in     (wb_in),
    .tx        (tx),
    .busy      (busy),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] npc, input logic [31:0] wb);
    @(negedge clk);
    trace_en = en;
    npc_in   = npc;
    wb_in    = wb;
  endtask

  task automatic doReset();
    @(negedge clk);
    RN       = 1'b1;
    trace_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    RN = 1'b0;
  endtask

  function automatic logic [79:0] modelFrame(input logic [31:0] npc, input logic [31:0] wb);
    logic [7:0] cs;
    cs = npc[7:0] ^ npc[15:8] ^ npc[23:16] ^ npc[31:24] ^ wb[7:0] ^ wb[15:8] ^ wb[23:16] ^ wb[31:24];
    return {8'hA5, npc[7:0], npc[15:8], npc[23:16], npc[31:24],
            wb[7:0], wb[15:8], wb[23:16], wb[31:24], cs};
  endfunction

  task automatic checkFrame(input string name, input int base, input logic [79:0] exp);
    logic [31:0] act;
    for (int i = 0; i < NB; i++) begin
      act = (base + i < rx_q.size()) ? {24'h0, rx_q[base + i]} : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s_byte%0d", name, i), act, {24'h0, exp[79 - 8*i -: 8]});
    end
  endtask

  // Wait for one frame and count the cycles busy stays high; ok=0 on timeout.
  task automatic waitFrame(output int span, output bit ok);
    int n;
    span = 0;
    ok   = 1'b0;
    n    = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy === 1'b1) begin
      while (busy === 1'b1 && span < 5000) begin
        span++;
        @(negedge clk);
      end
      ok = (busy !== 1'b1);
    end
  endtask

  // UART receiver: finds a start bit, samples mid-bit, queues each byte.
  initial begin
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) mon_err++;
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[b] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) mon_err++;
        rx_q.push_back(rx_byte);
      end
    end
  end

  // Guard against a hung design.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, want completion within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int  span;
    bit  ok;
    int  n;
    int  lvl_bad;

    vecs[0] = '{npc: 32'h0000_0004, wb: 32'h0000_0013, exp_bytes: 80'hA5_04_00_00_00_13_00_00_00_17};
    vecs[1] = '{npc: 32'h1234_5678, wb: 32'hDEAD_BEEF, exp_bytes: 80'hA5_78_56_34_12_EF_BE_AD_DE_2A};
    vecs[2] = '{npc: 32'h8000_0000, wb: 32'hFFFF_FFFF, exp_bytes: 80'hA5_00_00_00_80_FF_FF_FF_FF_80};
    vecs[3] = '{npc: 32'hA5A5_A5A4, wb: 32'h00FF_00FF, exp_bytes: 80'hA5_A4_A5_A5_A5_FF_00_FF_00_01};

    $display("[TB] start, frame bytes=%0d", NB);

    repeat (3) @(negedge clk);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_level", 32'(fifo_level), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    RN     = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vecs[i].npc, vecs[i].wb);
      waitFrame(span, ok);
      checkOutput($sformatf("vec%0d_done", i), 32'(ok), 32'd1);
      checkOutput($sformatf("vec%0d_span", i), 32'(span), 32'(SPAN));
      checkOutput($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt), 32'(i + 1));
      checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow), 32'd0);
      checkOutput($sformatf("vec%0d_tx_idle", i), 32'(tx), 32'd1);
      checkOutput($sformatf("vec%0d_nbytes", i), 32'(rx_q.size()), 32'(NB));
      checkFrame($sformatf("vec%0d", i), 0, vecs[i].exp_bytes);
      rx_q.delete();
    end

    $display("[TB] stable NPC");
    applyStimulus(1'b1, 32'h0000_0010, 32'h0000_0055);
    lvl_bad = 0;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (k >= 2 && fifo_level != '0) lvl_bad++;
    end
    checkOutput("stable_level_nonzero_cycles", 32'(lvl_bad), 32'd0);
    checkOutput("stable_frame_cnt", 32'(frame_cnt), 32'd5);
    checkOutput("stable_nbytes", 32'(rx_q.size()), 32'(NB));
    checkFrame("stable", 0, modelFrame(32'h0000_0010, 32'h0000_0055));
    rx_q.delete();

    $display("[TB] overflow");
    doReset();
    checkOutput("ovf_reset_frame_cnt", 32'(frame_cnt), 32'd0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        checkOutput("ovf_level_full", 32'(fifo_level), 32'(DEPTH));
        checkOutput("ovf_before_drop", 32'(overflow), 32'd0);
      end
      trace_en = 1'b1;
      npc_in   = 32'h100 + 32'(4 * k);
      wb_in    = 32'(k);
    end
    @(negedge clk);
    checkOutput("ovf_after_drop", 32'(overflow), 32'd1);
    checkOutput("ovf_level_held", 32'(fifo_level), 32'(DEPTH));
    n = 0;
    while (frame_cnt != 16'd9 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ovf_frames_in_time", 32'(n < 6000), 32'd1);
    repeat (500) @(negedge clk);
    checkOutput("ovf_frame_cnt", 32'(frame_cnt), 32'd9);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("ovf_nbytes", 32'(rx_q.size()), 32'(9 * NB));
    for (int f = 0; f < 9; f++) begin
      checkFrame($sformatf("ovf_f%0d", f), f * NB, modelFrame(32'h100 + 32'(4 * f), 32'(f)));
    end
    rx_q.delete();

    $display("[TB] reset mid-frame");
    doReset();
    checkOutput("mid_overflow_cleared", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 32'h0000_0200, 32'h0000_0300);
    n = 0;
    while (busy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mid_busy_start", 32'(busy), 32'd1);
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      if (c == 20) begin
        npc_in = 32'h0000_0204;
        wb_in  = 32'h0000_0304;
      end
    end
    checkOutput("mid_level_queued", 32'(fifo_level), 32'd1);
    checkOutput("mid_busy_before", 32'(busy), 32'd1);
    RN       = 1'b1;
    trace_en = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_tx", 32'(tx), 32'd1);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
    RN = 1'b0;
    repeat (80) @(negedge clk);
    rx_q.delete();
    applyStimulus(1'b1, 32'h0000_0400, 32'h0000_0001);
    waitFrame(span, ok);
    checkOutput("mid_new_done", 32'(ok), 32'd1);
    checkOutput("mid_new_frame_cnt", 32'(frame_cnt), 32'd1);
    checkFrame("mid_new", 0, modelFrame(32'h0000_0400, 32'h0000_0001));
    rx_q.delete();

    $display("[TB] enable gating");
    doReset();
    applyStimulus(1'b0, 32'h0000_0000, 32'h0);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0);
    applyStimulus(1'b0, 32'h0000_0008, 32'h0);
    applyStimulus(1'b0, 32'h0000_0008, 32'h0);
    checkOutput("gate_level_disabled", 32'(fifo_level), 32'd0);
    checkOutput("gate_busy_disabled", 32'(busy), 32'd0);
    applyStimulus(1'b1, 32'h0000_000C, 32'h0000_0077);
    waitFrame(span, ok);
    checkOutput("gate_done", 32'(ok), 32'd1);
    repeat (400) @(negedge clk);
    checkOutput("gate_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("gate_nbytes", 32'(rx_q.size()), 32'(NB));
    checkFrame("gate", 0, modelFrame(32'h0000_000C, 32'h0000_0077));

    checkOutput("monitor_framing_errors", 32'(mon_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sam_wb_trace_tx.md
Name: sam_wb_trace_tx

Overview:
Consumer end of the core's NPC/WB_OUT observation interface. Watches sam_rv32i NPC and WB_OUT and detects each retirement as a change in NPC. Buffers each {NPC, WB} record in a small FIFO and serialises it as a framed UART byte stream. This lets silicon/FPGA runs export the same trace the simulation bench prints.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (≥2)
DEPTH, 8, FIFO records; power of 2, ≥2

Ports:
clk  in  1  system clock
RN  in  1  synchronous active-high reset
trace_en  in  1  capture enable
npc_in  in  32  core NPC
wb_in  in  32  core WB_OUT
tx  out  1  UART serial out, idle high
busy  out  1  serialiser not IDLE
fifo_level  out  $clog2(DEPTH)+1  records queued
overflow  out  1  sticky, record dropped
frame_cnt  out  16  completed frames, wraps 0xFFFF→0

Behaviour:
- Reset (RN=1 at posedge): tx=1, busy=0, fifo_level=0, overflow=0, frame_cnt=0, npc_q=0, state=IDLE. Reset mid-frame aborts immediately: tx=1 the next cycle, queued records discarded.
- Detect: npc_q<=npc_in every cycle regardless of trace_en. push = trace_en && (npc_in != npc_q). Record = {npc_in, wb_in}, sampled the same cycle.
- FIFO: write registered; fifo_level updates the cycle after push.
- Full FIFO (level==DEPTH): push is accepted only if a pop occurs the same cycle; otherwise the record is dropped and overflow<=1. overflow is cleared only by RN.
- Empty FIFO: no pop.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE: if level>0, pop into frame register, byte_idx=0, go START. tx falls on the following cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx < FRAME_BYTES-1: byte_idx++, go START.
    - Else: frame_cnt++, go IDLE.
  - No idle gap between bytes of a frame. At least one IDLE cycle between frames.
- Frame layout (FRAME_BYTES=9):
  - byte0 = 0xA5 sync
  - bytes1-4 = NPC, little-endian
  - bytes5-8 = WB, little-endian
- busy = (state != IDLE).
- Bit timer: counts 0..CLKS_PER_BIT-1 and wraps; reset to 0 on every state entry.
- Throughput: sustained capture faster than one record per 9*10*CLKS_PER_BIT cycles eventually overflows. This is by design.

Optional Feature:
SAM_TRACE_CHECKSUM_EN
- Defined: FRAME_BYTES=10; byte9 = XOR of bytes1-8. Frame length 100*CLKS_PER_BIT cycles.
- Undefined: 9-byte frame, no checksum logic.

Decomposition:
- Package sam_trace_pkg: SYNC_BYTE=8'hA5, FRAME_BYTES (selected by macro), state enum {IDLE, START, DATA, STOP}, record typedef (struct of npc, wb, each 32 bits).
- Sub-module sam_trace_fifo: synchronous FIFO, DEPTH×64, push/pop/level/full/empty, same-cycle push+pop when full allowed.

Test Plan:
- Basic frame, CLKS_PER_BIT=4: reset, then npc_in 0→0x00000004 with wb_in=0x00000013 → tx carries A5 04 00 00 00 13 00 00 00. Frame spans 360 cycles; frame_cnt=1 afterwards; overflow=0.
- Stable NPC: hold npc_in=0x10 for 1000 cycles after one capture → exactly 1 frame, fifo_level stays 0 after the pop.
- Overflow, DEPTH=8: 10 distinct NPC values on 10 consecutive cycles → 9 frames emitted, overflow=1. The 10th record never appears; frame_cnt=9.
- Reset mid-frame: assert RN during DATA of byte3 → next cycle tx=1, busy=0, fifo_level=0, frame_cnt=0. The next capture after release starts a fresh frame with 0xA5.
- Enable gating: trace_en=0 while NPC changes 0→4→8, then trace_en=1 with NPC 8→C → exactly one frame, with NPC=0x0000000C.
- Checksum build (SAM_TRACE_CHECKSUM_EN): NPC=0x00000004, WB=0x00000013 → byte9=0x17, frame spans 400 cycles at CLKS_PER_BIT=4.
